// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone widths and arbiter state encoding
package wb_pkg;
   localparam int WB_DW = 16;
   localparam int WB_AW = 20;
   localparam int WB_SW = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GNT0 = 2'd1;
   localparam logic [1:0] ST_GNT1 = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_GNT0 = ST_GNT0,
      S_GNT1 = ST_GNT1
   } arb_state_t;
endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - stall counter that fakes an ack when a strobe is never acknowledged
module wb_arb_watchdog #(
   parameter int TO_CYCLES = 255,
   parameter int TO_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic stb,
   input  logic ack,
   output logic expire
);
   logic [TO_W-1:0] cnt;

   // A real ack in the expiry clock takes precedence over the fake one.
   assign expire = active & stb & ~ack & (cnt == TO_W'(TO_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!active || !stb || ack || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone arbiter, grant held for the whole CYC envelope
// Optional stall watchdog: define WB_ARB_TIMEOUT_EN.
module wb_arbiter2
   import wb_pkg::*;
#(
   parameter bit RR_EN     = 1'b1,
   parameter int TO_CYCLES = 255,
   parameter int TO_W      = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic [WB_DW-1:0] m0_dat_i,
   output logic [WB_DW-1:0] m0_dat_o,
   input  logic [WB_AW:1]   m0_adr_i,
   input  logic [WB_SW-1:0] m0_sel_i,
   input  logic             m0_we_i,
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   output logic             m0_ack_o,
   input  logic [WB_DW-1:0] m1_dat_i,
   output logic [WB_DW-1:0] m1_dat_o,
   input  logic [WB_AW:1]   m1_adr_i,
   input  logic [WB_SW-1:0] m1_sel_i,
   input  logic             m1_we_i,
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   output logic             m1_ack_o,
   output logic [WB_DW-1:0] s_dat_o,
   input  logic [WB_DW-1:0] s_dat_i,
   output logic [WB_AW:1]   s_adr_o,
   output logic [WB_SW-1:0] s_sel_o,
   output logic             s_we_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   input  logic             s_ack_i,
   output logic [1:0]       gnt_o,
   output logic             timeout_o
);
   arb_state_t state, state_next;
   logic       rr_last;
   logic       stb_raw;
   logic       expire;

   // Marker scope that only elaborates for an out-of-range watchdog setup.
   if (TO_CYCLES < 2 || TO_CYCLES >= (1 << TO_W)) begin : g_bad_to_cfg
   end

`ifdef WB_ARB_TIMEOUT_EN
   wb_arb_watchdog #(
      .TO_CYCLES(TO_CYCLES),
      .TO_W     (TO_W)
   ) u_watchdog (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n_i),
      .active(state != S_IDLE),
      .stb   (stb_raw),
      .ack   (s_ack_i),
      .expire(expire)
   );
   assign timeout_o = expire;
`else
   assign expire    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state   <= S_IDLE;
         rr_last <= 1'b1;
      end else begin
         state <= state_next;
         if (state == S_IDLE && state_next == S_GNT0) rr_last <= 1'b0;
         if (state == S_IDLE && state_next == S_GNT1) rr_last <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               if (RR_EN) state_next = rr_last ? S_GNT0 : S_GNT1;
               else       state_next = S_GNT0;
            end else if (m0_cyc_i) begin
               state_next = S_GNT0;
            end else if (m1_cyc_i) begin
               state_next = S_GNT1;
            end
         end
         // Dropping CYC always returns through IDLE: one dead clock between owners.
         S_GNT0:  if (!m0_cyc_i) state_next = S_IDLE;
         S_GNT1:  if (!m1_cyc_i) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign gnt_o   = {state == S_GNT1, state == S_GNT0};
   assign s_stb_o = stb_raw & ~expire;

   always_comb begin
      s_adr_o  = '0;
      s_sel_o  = '0;
      s_dat_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      stb_raw  = 1'b0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      unique case (state)
         S_GNT0: begin
            s_adr_o  = m0_adr_i;
            s_sel_o  = m0_sel_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            stb_raw  = m0_cyc_i & m0_stb_i;
            m0_ack_o = s_ack_i | expire;
            if (expire) m0_dat_o = 16'hFFFF;
         end
         S_GNT1: begin
            s_adr_o  = m1_adr_i;
            s_sel_o  = m1_sel_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            stb_raw  = m1_cyc_i & m1_stb_i;
            m1_ack_o = s_ack_i | expire;
            if (expire) m1_dat_o = 16'hFFFF;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - checks a round-robin and a fixed-priority arbiter against a grant-owner model
module tb_wb_arbiter2;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] m0_dat, m1_dat, s_dat;
   logic [20:1] m0_adr, m1_adr;
   logic [1:0]  m0_sel, m1_sel;
   logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack;

   logic [15:0] o_m0_dat [2];
   logic [15:0] o_m1_dat [2];
   logic [15:0] o_s_dat  [2];
   logic [20:1] o_s_adr  [2];
   logic [1:0]  o_s_sel  [2];
   logic [1:0]  o_gnt    [2];
   logic        o_m0_ack [2];
   logic        o_m1_ack [2];
   logic        o_s_we   [2];
   logic        o_s_cyc  [2];
   logic        o_s_stb  [2];
   logic        o_to     [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Instance 0 is round-robin, instance 1 is fixed priority; both see the same masters and slave.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      wb_arbiter2 #(.RR_EN(g == 0), .TO_CYCLES(TO), .TO_W(4)) u_dut (
         .wb_clk_i(clk), .wb_rst_n_i(rst_n),
         .m0_dat_i(m0_dat), .m0_dat_o(o_m0_dat[g]), .m0_adr_i(m0_adr), .m0_sel_i(m0_sel),
         .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(o_m0_ack[g]),
         .m1_dat_i(m1_dat), .m1_dat_o(o_m1_dat[g]), .m1_adr_i(m1_adr), .m1_sel_i(m1_sel),
         .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(o_m1_ack[g]),
         .s_dat_o(o_s_dat[g]), .s_dat_i(s_dat), .s_adr_o(o_s_adr[g]), .s_sel_o(o_s_sel[g]),
         .s_we_o(o_s_we[g]), .s_cyc_o(o_s_cyc[g]), .s_stb_o(o_s_stb[g]), .s_ack_i(s_ack),
         .gnt_o(o_gnt[g]), .timeout_o(o_to[g])
      );
   end

   // Model: who owns the bus (-1 none), who won the last arbitration, stalled-strobe age.
   int own  [2] = '{-1, -1};
   int last [2] = '{1, 1};
   int age  [2] = '{0, 0};

   function automatic logic mcyc(input int m);
      return (m == 0) ? m0_cyc : (m == 1) ? m1_cyc : 1'b0;
   endfunction

   function automatic logic mstb(input int m);
      return mcyc(m) && ((m == 0) ? m0_stb : m1_stb);
   endfunction

   function automatic logic fake_ack(input int i);
`ifdef WB_ARB_TIMEOUT_EN
      return mstb(own[i]) && !s_ack && age[i] == TO;
`else
      return (i < 0);
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            own[i] = -1; last[i] = 1; age[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (mstb(own[i]) && !s_ack && !fake_ack(i)) age[i] = age[i] + 1;
            else age[i] = 0;
            if (own[i] < 0) begin
               if (m0_cyc && m1_cyc) own[i] = (i == 0) ? 1 - last[i] : 0;
               else if (m0_cyc) own[i] = 0;
               else if (m1_cyc) own[i] = 1;
               if (own[i] >= 0) last[i] = own[i];
            end else if (!mcyc(own[i])) begin
               own[i] = -1;
            end
         end
      end
   end

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, inst, $time, act, exp);
      end
   endtask

   task automatic compare_inst(input int i);
      int   o;
      logic fa;
      o  = own[i];
      fa = fake_ack(i);
      chk("gnt",     i, o_gnt[i],    (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00);
      chk("s_adr",   i, o_s_adr[i],  (o == 0) ? m0_adr : (o == 1) ? m1_adr : 20'h0);
      chk("s_sel",   i, o_s_sel[i],  (o == 0) ? m0_sel : (o == 1) ? m1_sel : 2'b0);
      chk("s_dat",   i, o_s_dat[i],  (o == 0) ? m0_dat : (o == 1) ? m1_dat : 16'h0);
      chk("s_we",    i, o_s_we[i],   (o == 0) ? m0_we : (o == 1) ? m1_we : 1'b0);
      chk("s_cyc",   i, o_s_cyc[i],  mcyc(o));
      chk("s_stb",   i, o_s_stb[i],  mstb(o) && !fa);
      chk("m0_ack",  i, o_m0_ack[i], o == 0 && (s_ack || fa));
      chk("m1_ack",  i, o_m1_ack[i], o == 1 && (s_ack || fa));
      chk("m0_dat",  i, o_m0_dat[i], (o == 0 && fa) ? 16'hFFFF : s_dat);
      chk("m1_dat",  i, o_m1_dat[i], (o == 1 && fa) ? 16'hFFFF : s_dat);
      chk("timeout", i, o_to[i],     fa);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) compare_inst(i);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
      m0_dat = 16'hA0A0; m1_dat = 16'hB1B1; s_dat = 16'h5A5A;
      m0_adr = 20'h00400; m1_adr = 20'h0F00F; m0_sel = 2'b11; m1_sel = 2'b01;
      step(); step();
      chk("rst_gnt", 0, o_gnt[0], 2'b00);
      chk("rst_cyc", 0, o_s_cyc[0], 1'b0);
      chk("rst_adr", 0, o_s_adr[0], 20'h0);
      chk("rst_to",  0, o_to[0], 1'b0);
      rst_n = 1'b1;
      step();

      // m0 single read, slave acks two clocks after the strobe appears
      m0_cyc = 1; m0_stb = 1; m0_we = 0;
      #1;
      chk("t1_gnt_req", 0, o_gnt[0], 2'b00);
      chk("t1_stb_req", 0, o_s_stb[0], 1'b0);
      step();
      chk("t1_gnt", 0, o_gnt[0], 2'b01);
      chk("t1_stb", 0, o_s_stb[0], 1'b1);
      chk("t1_adr", 0, o_s_adr[0], 20'h00400);
      step(); step();
      s_ack = 1; s_dat = 16'h1234;
      #1;
      chk("t1_ack",   0, o_m0_ack[0], 1'b1);
      chk("t1_dat",   0, o_m0_dat[0], 16'h1234);
      chk("t1_m1ack", 0, o_m1_ack[0], 1'b0);
      step();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      step();
      chk("t1_idle", 0, o_gnt[0], 2'b00);

      // simultaneous requests right after reset
      do_reset();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      step();
      chk("t2_first_rr", 0, o_gnt[0], 2'b01);
      chk("t2_first_fp", 1, o_gnt[1], 2'b01);
      s_ack = 1;
      #1;
      chk("t2_m0ack", 0, o_m0_ack[0], 1'b1);
      chk("t2_m1ack", 0, o_m1_ack[0], 1'b0);
      step();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      step();
      chk("t2_dead", 0, o_gnt[0], 2'b00);
      step();
      chk("t2_second_rr", 0, o_gnt[0], 2'b10);
      s_ack = 1;
      #1;
      chk("t2_m1ack2", 0, o_m1_ack[0], 1'b1);
      step();
      s_ack = 0; m1_cyc = 0; m1_stb = 0;
      step();

      // both masters keep asking; fixed priority always returns to m0
      do_reset();
      m1_cyc = 1; m1_stb = 1; m0_cyc = 1; m0_stb = 1;
      for (int r = 0; r < 3; r++) begin
         step();
         chk("t3_fp_gnt", 1, o_gnt[1], 2'b01);
         s_ack = 1;
         step();
         s_ack = 0; m0_cyc = 0; m0_stb = 0;
         step();
         chk("t3_fp_idle", 1, o_gnt[1], 2'b00);
         m0_cyc = 1; m0_stb = 1;
      end
      {m0_cyc, m0_stb, m1_cyc, m1_stb} = '0;
      step(); step(); step();

      // m0 keeps CYC across three strobe beats while m1 waits
      do_reset();
      m0_cyc = 1; m1_cyc = 1; m1_stb = 1;
      step();
      for (int b = 0; b < 3; b++) begin
         m0_stb = 1; s_ack = 1; s_dat = 16'h0100 + 16'(b);
         #1;
         chk("t4_gnt",    0, o_gnt[0], 2'b01);
         chk("t4_m0ack",  0, o_m0_ack[0], 1'b1);
         chk("t4_m1ack",  0, o_m1_ack[0], 1'b0);
         chk("t4_m0dat",  0, o_m0_dat[0], 16'h0100 + 16'(b));
         step();
         m0_stb = 0; s_ack = 0;
         step();
      end
      m0_cyc = 0;
      step();
      chk("t4_dead", 0, o_gnt[0], 2'b00);
      step();
      chk("t4_m1_rr", 0, o_gnt[0], 2'b10);
      chk("t4_m1_fp", 1, o_gnt[1], 2'b10);
      m1_cyc = 0; m1_stb = 0;
      step(); step();

      // slave never acks
      do_reset();
      s_dat = 16'h5A5A;
      m0_cyc = 1; m0_stb = 1;
      step();
      for (int k = 0; k < TO; k++) begin
         chk("t5_stb_wait", 0, o_s_stb[0], 1'b1);
         chk("t5_ack_wait", 0, o_m0_ack[0], 1'b0);
         step();
      end
`ifdef WB_ARB_TIMEOUT_EN
      chk("t5_to_ack", 0, o_m0_ack[0], 1'b1);
      chk("t5_to_dat", 0, o_m0_dat[0], 16'hFFFF);
      chk("t5_to_pls", 0, o_to[0], 1'b1);
      chk("t5_to_stb", 0, o_s_stb[0], 1'b0);
`else
      chk("t5_hang_ack", 0, o_m0_ack[0], 1'b0);
      chk("t5_hang_to",  0, o_to[0], 1'b0);
      chk("t5_hang_stb", 0, o_s_stb[0], 1'b1);
`endif
      step();
      chk("t5_after_ack", 0, o_m0_ack[0], 1'b0);
      chk("t5_after_to",  0, o_to[0], 1'b0);
      m0_cyc = 0; m0_stb = 0;
      step(); step();

      // asynchronous reset in the middle of an m1 access
      do_reset();
      m1_cyc = 1; m1_stb = 1;
      step();
      chk("t6_gnt", 0, o_gnt[0], 2'b10);
      #2;
      rst_n = 0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("t6_rst_gnt", i, o_gnt[i], 2'b00);
         chk("t6_rst_cyc", i, o_s_cyc[i], 1'b0);
         chk("t6_rst_stb", i, o_s_stb[i], 1'b0);
      end
      step();
      rst_n = 1; s_ack = 1;
      #1;
      chk("t6_late_ack_rr", 0, o_m1_ack[0], 1'b0);
      chk("t6_late_ack_fp", 1, o_m1_ack[1], 1'b0);
      #1;
      s_ack = 0; m1_cyc = 0; m1_stb = 0;
      step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
